// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake with pipeline stall, timeout abort,
// store lane steering and load extraction. Optional misalignment trap enabled by MISALIGN_TRAP_EN.
module mem_stage_lsu #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_mem_valid,
   input  logic              ex_mem_memread,
   input  logic              ex_mem_memwrite,
   input  logic [2:0]        ex_mem_funct3,
   input  logic [ADDR_W-1:0] ex_mem_addr,
   input  logic [31:0]       write_data2,
   output logic              mem_stall,
   output logic [31:0]       read_data,
   output logic              read_valid,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic              bus_err,
   output logic              misalign_err
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        alo_q, alo_d;
   logic [31:0]       read_data_q, read_data_d;
   logic              read_valid_q, read_valid_d;
   logic              bus_err_q, bus_err_d;
   logic              misalign_err_q, misalign_err_d;
   logic              access_s;
   logic              trap_s;

   // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
   function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   store_be = 4'b0001 << a;
         2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
         default: store_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'b00:   store_wdata = {4{d[7:0]}};
         2'b01:   store_wdata = {2{d[15:0]}};
         default: store_wdata = d;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = w >> {a, 3'b000};
      b  = sh[7:0];
      h  = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_extract = {{24{b[7]}}, b};
         3'b100:  load_extract = {24'd0, b};
         3'b001:  load_extract = {{16{h[15]}}, h};
         3'b101:  load_extract = {16'd0, h};
         default: load_extract = w;
      endcase
   endfunction

`ifdef MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = a[0];
         default: is_misaligned = (a != 2'b00);
      endcase
   endfunction

   assign trap_s = is_misaligned(ex_mem_funct3[1:0], ex_mem_addr[1:0]);
`else
   assign trap_s = 1'b0;
`endif

   assign access_s = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);

   // Next-state, latched bus request and DONE-cycle result generation.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bus_req_d      = bus_req_q;
      bus_we_d       = bus_we_q;
      bus_addr_d     = bus_addr_q;
      bus_wdata_d    = bus_wdata_q;
      bus_be_d       = bus_be_q;
      f3_d           = f3_q;
      alo_d          = alo_q;
      read_data_d    = 32'd0;
      read_valid_d   = 1'b0;
      bus_err_d      = 1'b0;
      misalign_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access_s) begin
               bus_we_d    = ex_mem_memwrite;
               bus_addr_d  = {ex_mem_addr[ADDR_W-1:2], 2'b00};
               f3_d        = ex_mem_funct3;
               alo_d       = ex_mem_addr[1:0];
               bus_be_d    = ex_mem_memwrite ? store_be(ex_mem_funct3[1:0], ex_mem_addr[1:0])
                                             : 4'b1111;
               bus_wdata_d = ex_mem_memwrite ? store_wdata(ex_mem_funct3[1:0], write_data2)
                                             : 32'd0;
               cnt_d       = {CNT_W{1'b0}};
               if (trap_s) begin
                  state_d        = ST_DONE;
                  misalign_err_d = 1'b1;
               end else begin
                  state_d   = ST_REQ;
                  bus_req_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus_ack) begin
               state_d      = ST_DONE;
               bus_req_d    = 1'b0;
               read_valid_d = ~bus_we_q;
               read_data_d  = bus_we_q ? 32'd0 : load_extract(f3_q, alo_q, bus_rdata);
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
         default: begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
            cnt_d     = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and registered-output update; async reset drops bus_req immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= {CNT_W{1'b0}};
         bus_req_q      <= 1'b0;
         bus_we_q       <= 1'b0;
         bus_addr_q     <= {ADDR_W{1'b0}};
         bus_wdata_q    <= 32'd0;
         bus_be_q       <= 4'b0000;
         f3_q           <= 3'b000;
         alo_q          <= 2'b00;
         read_data_q    <= 32'd0;
         read_valid_q   <= 1'b0;
         bus_err_q      <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bus_req_q      <= bus_req_d;
         bus_we_q       <= bus_we_d;
         bus_addr_q     <= bus_addr_d;
         bus_wdata_q    <= bus_wdata_d;
         bus_be_q       <= bus_be_d;
         f3_q           <= f3_d;
         alo_q          <= alo_d;
         read_data_q    <= read_data_d;
         read_valid_q   <= read_valid_d;
         bus_err_q      <= bus_err_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   // Stall covers the IDLE cycle an access is seen plus every REQ cycle; forced low in reset.
   assign mem_stall    = rst_n & (((state_q == ST_IDLE) & access_s) | (state_q == ST_REQ));
   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign bus_be       = bus_be_q;
   assign read_data    = read_data_q;
   assign read_valid   = read_valid_q;
   assign bus_err      = bus_err_q;
   assign misalign_err = misalign_err_q;

endmodule
